// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT pipeline constants and read-side state type
package fft_pkg;
  localparam int LANES = 16;
  localparam int BLK_BEATS = 4;
  localparam int S0_CBFP_IN_W = 23;
  localparam int S0_OUT_W = 11;
  typedef enum logic {IDLE, DRAIN} rd_state_t;
endpackage

// File: rtl/cbfp_sign_count.sv
// cbfp_sign_count: number of consecutive bits below the MSB equal to the MSB
module cbfp_sign_count #(
  parameter int W = 23,
  parameter int EW = 5
) (
  input  logic [W-1:0]  x,
  output logic [EW-1:0] sc
);
  always_comb begin
    sc = EW'(W - 1);
    for (int i = 0; i <= W - 2; i++) sc = (x[i] != x[W-1]) ? EW'(W - 2 - i) : sc;
  end
endmodule

// File: rtl/cbfp_0.sv
// cbfp_0: stage-0 convergent block-floating-point normaliser with ping-pong banks
module cbfp_0 #(
  parameter int IN_WIDTH = fft_pkg::S0_CBFP_IN_W,
  parameter int OUT_WIDTH = fft_pkg::S0_OUT_W,
  parameter int LANES = fft_pkg::LANES,
  parameter int BLK_BEATS = fft_pkg::BLK_BEATS,
  parameter int EXP_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [IN_WIDTH-1:0]  in_re [0:LANES-1],
  input  logic signed [IN_WIDTH-1:0]  in_im [0:LANES-1],
  input  logic                        din_valid,
  output logic signed [OUT_WIDTH-1:0] out_re [0:LANES-1],
  output logic signed [OUT_WIDTH-1:0] out_im [0:LANES-1],
  output logic [EXP_WIDTH-1:0]        out_exp,
  output logic                        dout_valid,
  output logic                        dout_last
);
  import fft_pkg::*;
  localparam int CW = $clog2(BLK_BEATS);
  localparam logic [CW-1:0] LAST = CW'(BLK_BEATS - 1);
  localparam logic [EXP_WIDTH-1:0] SC_MAX = EXP_WIDTH'(IN_WIDTH - 1);
  logic [EXP_WIDTH-1:0] sc_re [LANES];
  logic [EXP_WIDTH-1:0] sc_im [LANES];
  logic [EXP_WIDTH-1:0] beat_min, blk_min, blk_end_min;
  logic [EXP_WIDTH-1:0] blk_exp [2];
  logic signed [IN_WIDTH-1:0] mem_re [2][BLK_BEATS][LANES];
  logic signed [IN_WIDTH-1:0] mem_im [2][BLK_BEATS][LANES];
  logic [CW-1:0] wr_cnt, rd_cnt, rd_cnt_nx;
  logic wr_bank, rd_bank, rd_bank_nx, close;
  rd_state_t state, state_nx;

  for (genvar g = 0; g < LANES; g++) begin : g_sc
    cbfp_sign_count #(.W(IN_WIDTH), .EW(EXP_WIDTH)) u_re (.x(in_re[g]), .sc(sc_re[g]));
    cbfp_sign_count #(.W(IN_WIDTH), .EW(EXP_WIDTH)) u_im (.x(in_im[g]), .sc(sc_im[g]));
  end

  always_comb begin
    beat_min = SC_MAX;
    for (int l = 0; l < LANES; l++) begin
      beat_min = (sc_re[l] < beat_min) ? sc_re[l] : beat_min;
      beat_min = (sc_im[l] < beat_min) ? sc_im[l] : beat_min;
    end
  end

  assign blk_end_min = (beat_min < blk_min) ? beat_min : blk_min;
  assign close = din_valid && wr_cnt == LAST;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      blk_min <= SC_MAX;
      blk_exp <= '{default: '0};
    end else if (din_valid) begin
      wr_cnt <= close ? '0 : wr_cnt + 1'b1;
      wr_bank <= wr_bank ^ close;
      blk_min <= close ? SC_MAX : blk_end_min;
      if (close) blk_exp[wr_bank] <= blk_end_min;
    end

  // Sample storage carries no reset: stale contents are never read before being rewritten.
  always_ff @(posedge clk)
    if (din_valid) begin
      mem_re[wr_bank][wr_cnt] <= in_re;
      mem_im[wr_bank][wr_cnt] <= in_im;
    end

  // A new block can only close exactly as slot 3 drains, so no pending flag is needed.
  always_comb begin
    state_nx = state;
    rd_bank_nx = rd_bank;
    rd_cnt_nx = (state == DRAIN) ? rd_cnt + 1'b1 : rd_cnt;
    if (state == DRAIN && rd_cnt == LAST) state_nx = IDLE;
    if (close && (state == IDLE || rd_cnt == LAST)) begin
      state_nx = DRAIN;
      rd_bank_nx = wr_bank;
      rd_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt <= '0;
    end else begin
      state <= state_nx;
      rd_bank <= rd_bank_nx;
      rd_cnt <= rd_cnt_nx;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_re <= '{default: '0};
      out_im <= '{default: '0};
      out_exp <= '0;
      dout_valid <= 1'b0;
      dout_last <= 1'b0;
    end else begin
      dout_valid <= state == DRAIN;
      dout_last <= state == DRAIN && rd_cnt == LAST;
      if (state == DRAIN) begin
        out_exp <= blk_exp[rd_bank];
        for (int l = 0; l < LANES; l++) begin
          out_re[l] <= OUT_WIDTH'(mem_re[rd_bank][rd_cnt][l] <<< blk_exp[rd_bank] >>> (IN_WIDTH - OUT_WIDTH));
          out_im[l] <= OUT_WIDTH'(mem_im[rd_bank][rd_cnt][l] <<< blk_exp[rd_bank] >>> (IN_WIDTH - OUT_WIDTH));
        end
      end
    end
endmodule

// File: tb/tb_cbfp_0.sv
// tb_cbfp_0: directed scoreboard bench for the stage-0 CBFP normaliser
module tb_cbfp_0;
  typedef struct packed {
    logic [15:0][10:0] re;
    logic [15:0][10:0] im;
    logic [4:0] ex;
    logic last;
    int cyc;
  } exp_t;

  logic clk = 1'b0, rstn = 1'b0, din_valid = 1'b0;
  logic signed [22:0] in_re [0:15];
  logic signed [22:0] in_im [0:15];
  logic signed [10:0] out_re [0:15];
  logic signed [10:0] out_im [0:15];
  logic [4:0] out_exp;
  logic dout_valid, dout_last;
  int checks = 0, errors = 0, cyc = 0;
  int bre [4][16];
  int bim [4][16];
  logic signed [10:0] ere [4][16];
  logic signed [10:0] eim [4][16];
  logic [4:0] bexp;
  exp_t q[$];

  cbfp_0 dut (.clk(clk), .rstn(rstn), .in_re(in_re), .in_im(in_im), .din_valid(din_valid),
              .out_re(out_re), .out_im(out_im), .out_exp(out_exp), .dout_valid(dout_valid),
              .dout_last(dout_last));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int bad;
    if (rstn && dout_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid at cycle %0d: dout_valid=1 with no block pending", cyc);
      end else begin
        e = q.pop_front();
        checks += 4;
        if (cyc != e.cyc) begin errors++; $display("FAIL beat_cycle got %0d want %0d", cyc, e.cyc); end
        if (out_exp !== e.ex) begin errors++; $display("FAIL out_exp got %0d want %0d", out_exp, e.ex); end
        if (dout_last !== e.last) begin errors++; $display("FAIL dout_last got %0b want %0b", dout_last, e.last); end
        bad = -1;
        for (int l = 15; l >= 0; l--) if (out_re[l] !== e.re[l] || out_im[l] !== e.im[l]) bad = l;
        if (bad >= 0) begin
          errors++;
          $display("FAIL lane_data lane %0d got re=%0d im=%0d want re=%0d im=%0d", bad,
                   out_re[bad], out_im[bad], $signed(e.re[bad]), $signed(e.im[bad]));
        end
      end
    end
  end

  task automatic beat(input int b, input bit v);
    exp_t e;
    if (v) for (int l = 0; l < 16; l++) begin
      in_re[l] = 23'(bre[b][l]);
      in_im[l] = 23'(bim[b][l]);
    end
    din_valid = v;
    if (v && b == 3) for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 16; l++) begin
        e.re[l] = ere[j][l];
        e.im[l] = eim[j][l];
      end
      e.ex = bexp;
      e.last = (j == 3);
      e.cyc = cyc + 2 + j;
      q.push_back(e);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic run_block(input int n, input bit [7:0] pat);
    int b = 0;
    for (int i = 0; i < n; i++) begin
      beat(pat[i] ? b : 0, pat[i]);
      if (pat[i]) b++;
    end
  endtask

  task automatic fill(input int mode);
    for (int b = 0; b < 4; b++) for (int l = 0; l < 16; l++) begin
      case (mode)
        0: begin bre[b][l] = 0; bim[b][l] = 0; end
        1: begin bre[b][l] = int'($urandom_range(0, 1998)) - 999; bim[b][l] = int'($urandom_range(0, 1998)) - 999; end
        2: begin bre[b][l] = l * 311 - 2000 + b * 17; bim[b][l] = -bre[b][l]; end
        default: begin bre[b][l] = int'($urandom_range(0, 198)) - 99; bim[b][l] = int'($urandom_range(0, 198)) - 99; end
      endcase
    end
  endtask

  task automatic expect_scaled(input int mul, input int shr);
    for (int b = 0; b < 4; b++) for (int l = 0; l < 16; l++) begin
      ere[b][l] = 11'((bre[b][l] * mul) >>> shr);
      eim[b][l] = 11'((bim[b][l] * mul) >>> shr);
    end
  endtask

  initial begin
    repeat (6) begin
      for (int l = 0; l < 16; l++) begin in_re[l] = 23'($urandom); in_im[l] = 23'($urandom); end
      din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0 || dout_last !== 1'b0 || out_exp !== 5'd0) begin
        errors++;
        $display("FAIL reset_ctrl got valid=%0b last=%0b exp=%0d want 0 0 0", dout_valid, dout_last, out_exp);
      end
      for (int l = 0; l < 16; l++) begin
        checks++;
        if (out_re[l] !== 11'sd0 || out_im[l] !== 11'sd0) begin
          errors++;
          $display("FAIL reset_data lane %0d got re=%0d im=%0d want 0", l, out_re[l], out_im[l]);
        end
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    fill(0); bexp = 5'd22; expect_scaled(1, 0);
    run_block(4, 8'b1111);
    repeat (6) beat(0, 0);

    fill(1); bre[2][0] = 1000; bexp = 5'd12; expect_scaled(1, 0);
    run_block(4, 8'b1111);
    repeat (6) beat(0, 0);

    fill(0);
    bim[0][3] = -2097152; bre[1][5] = 4096; bim[2][7] = 4095; bre[3][15] = -1;
    bexp = 5'd1; expect_scaled(1, 0);
    eim[0][3] = -11'sd1024; ere[1][5] = 11'sd2; eim[2][7] = 11'sd1; ere[3][15] = -11'sd1;
    run_block(4, 8'b1111);
    repeat (6) beat(0, 0);

    fill(2); bre[1][9] = 5000; bexp = 5'd9; expect_scaled(1, 3);
    run_block(6, 8'b101101);
    repeat (6) beat(0, 0);

    fill(1); bre[0][0] = 1000; bexp = 5'd12; expect_scaled(1, 0);
    run_block(4, 8'b1111);
    fill(3); bim[3][4] = 100; bexp = 5'd15; expect_scaled(8, 0);
    run_block(4, 8'b1111);
    repeat (8) beat(0, 0);

    fill(1); bexp = 5'd12;
    beat(0, 1); beat(1, 1);
    for (int l = 0; l < 16; l++) begin in_re[l] = 23'(bre[2][l]); in_im[l] = 23'(bim[2][l]); end
    din_valid = 1'b1;
    #2 rstn = 1'b0;
    #4 rstn = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    repeat (3) beat(0, 0);

    fill(1); bim[1][11] = -1000; bexp = 5'd12; expect_scaled(1, 0);
    run_block(4, 8'b1111);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats still pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbfp_0.md
# cbfp_0

Convergent block-floating-point normaliser placed directly after the stage-0 butterfly/twiddle chain (module_02 output, `CBFP_valid`). It takes 16 complex lanes per beat at the widened stage-0 width, groups 4 valid beats into a 64-point block, and finds the smallest redundant-sign-bit count across the block. It then re-emits the block scaled to the narrow width consumed by the next FFT stage, tagged with a per-block exponent. A ping-pong buffer lets a new block fill while the previous one drains.

## Interface
- `IN_WIDTH`, 23, input sample width (signed, both re and im).
- `OUT_WIDTH`, 11, output sample width (signed).
- `LANES`, 16, parallel complex samples per beat.
- `BLK_BEATS`, 4, valid beats per CBFP block.
- `EXP_WIDTH`, 5, width of the exponent; equals `$clog2(IN_WIDTH)`.

- `clk`  in  1  single clock; everything is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_re[0:LANES-1]`  in  IN_WIDTH signed each  real input lanes.
- `in_im[0:LANES-1]`  in  IN_WIDTH signed each  imaginary input lanes.
- `din_valid`  in  1  beat qualifier; driven from `CBFP_valid`.
- `out_re[0:LANES-1]`  out  OUT_WIDTH signed each  normalised real lanes.
- `out_im[0:LANES-1]`  out  OUT_WIDTH signed each  normalised imaginary lanes.
- `out_exp`  out  EXP_WIDTH  block shift `s`, held for every beat of the block.
- `dout_valid`  out  1  output beat qualifier.
- `dout_last`  out  1  high on the final (4th) output beat of a block.

## Operation
- **Sign count.** `sc(x)` is the number of consecutive bits below the MSB that equal the MSB.
  - Range is 0..IN_WIDTH-1. `sc(0) = sc(-1) = 22`.
- **Beat minimum.** Each valid beat computes the minimum of `sc` over all 32 values (16 re + 16 im).
- **Block minimum.** A running `blk_min` takes the minimum across beats.
  - It is reset to IN_WIDTH-1 at the start of each block.
- **Write side.** The beat counter `wr_cnt` (0..3) advances only on `din_valid`.
  - Each beat is stored in bank `wr_bank`, slot `wr_cnt`.
  - When the 4th beat is accepted, the block closes:
    - `s = min(blk_min, beat_min)` is latched for that bank.
    - `wr_bank` toggles.
    - `wr_cnt` returns to 0.
- **Read side FSM.** Two states, IDLE and DRAIN.
  - IDLE → DRAIN on the cycle after a block closes; `rd_bank` is set to the closed bank and `rd_cnt` to 0.
  - DRAIN emits slot `rd_cnt` each cycle.
  - After slot 3: if another block closed meanwhile, the FSM stays in DRAIN on the other bank; otherwise it returns to IDLE.
- **Scaling.** For each lane, `out = (x <<< s)[IN_WIDTH-1 -: OUT_WIDTH]`.
  - This is truncation toward −∞. No rounding and no saturation are needed, because `s ≤ sc` guarantees no overflow.
- **Gapped input.** `din_valid` may have gaps of any length. Blocks are defined by valid-beat count only.
- **Overflow.** Cannot occur. A block needs ≥4 input cycles and drains in exactly 4 cycles, so two banks suffice.
- **Reset (at start or mid-block).**
  - Counters, banks, FSM and the partial block are discarded.
  - The next valid beat after `rstn` deasserts is beat 0 of a new block.

## Timing
- **Reset values:**
  - `out_re` = 0 and `out_im` = 0 for all lanes.
  - `out_exp` = 0.
  - `dout_valid` = 0 and `dout_last` = 0.
  - FSM = IDLE, `wr_cnt` = 0, `wr_bank` = 0.
- **Latency.** Let the 4th beat be sampled at edge T.
  - Output beat j (j = 0..3) is registered at edge T+1+j.
  - `dout_valid` is high for exactly 4 consecutive cycles; `dout_last` is high at T+4.
- **Continuous input** gives continuous output with fixed 1-cycle latency and no bubbles.
- **Simultaneous events.** A block closing in the same cycle as slot 3 draining goes straight into DRAIN of the new bank, with no IDLE cycle.
- **Idle outputs.** When `dout_valid` is 0, the data outputs hold their last values; their contents are don't-care.

## Structure
- **Shared package `fft_pkg`:**
  - Constants `LANES` = 16, `BLK_BEATS` = 4, `S0_CBFP_IN_W` = 23, `S0_OUT_W` = 11.
  - Typedef `rd_state_t` {IDLE, DRAIN}.
- **Sub-module `cbfp_sign_count`:** combinational IN_WIDTH → EXP_WIDTH `sc()`, instantiated 32×.
- **Top level** contains the min tree, banks, counters, FSM and scaling.
- **Size target:** about 200–300 RTL lines.

## Test plan
- **Reset.** Hold `rstn` = 0 while driving random data with `din_valid` = 1 → all outputs stay 0 and `dout_valid` never rises.
- **All-zero block.** 4 continuous beats of zeros → `dout_valid` high T+1..T+4, all outputs 0, `out_exp` = 22, `dout_last` only at T+4.
- **Mixed small values.** Beat 2, lane 0, re = 1000; all other values |x| < 1000 → `out_exp` = 12 and every output equals its input value.
- **Large negative block.** Beat 0, lane 3, im = −2097152; the same block also contains 4096, 4095 and −1 → `out_exp` = 1; outputs are −1024, 2, 1 and −1 respectively.
- **Gapped input.** `din_valid` = 1,0,1,1,0,1 → block closes on the 6th cycle; outputs follow in the 4 cycles after it, in slot order.
- **Back-to-back blocks and reset.**
  - 8 continuous beats, with block A max 1000 and block B max 100 → 8 consecutive valid beats; `out_exp` is 12 for beats 1–4 and 15 for beats 5–8.
  - Then pulse `rstn` low during beat 2 of a third block → no output appears from it, and the following full block normalises correctly.
